// File: rtl/tbb.sv
// Task Batch Buffer: loads one batch of NUM_LINES wide lines from the host into a
// simple-dual-port BRAM, then serves it to a PE Array as 32-bit words (word 0 = MSW).
module tbb #(
  parameter int TBB_WR_ADDR_WIDTH = 8,
  parameter int TBB_WR_DATA_WIDTH = 512,
  parameter int TBB_RD_ADDR_WIDTH = 12,
  parameter int TBB_RD_DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         task_start,
  output logic                         ReqValid,
  output logic [TBB_WR_ADDR_WIDTH-1:0] ReqLineIdx,
  input  logic                         ReqAck,
  input  logic                         RspValid,
  input  logic [TBB_WR_ADDR_WIDTH-1:0] RspLineIdx,
  input  logic [TBB_WR_DATA_WIDTH-1:0] RspDin,
  output logic                         Ready,
  output logic                         Empty,
  input  logic                         RdEn,
  input  logic [TBB_RD_ADDR_WIDTH-1:0] RdAddr,
  output logic                         RdValid,
  output logic [TBB_RD_DATA_WIDTH-1:0] RdDout,
  input  logic                         task_done,
  output logic                         LoadCmp
);

  localparam int NUM_LINES  = 1 << TBB_WR_ADDR_WIDTH;
  localparam int CNT_W      = TBB_WR_ADDR_WIDTH + 1;
  localparam int WORD_SEL_W = TBB_RD_ADDR_WIDTH - TBB_WR_ADDR_WIDTH;
  localparam int WORDS      = TBB_WR_DATA_WIDTH / TBB_RD_DATA_WIDTH;

  localparam logic [CNT_W-1:0] NUM_LINES_C = CNT_W'(NUM_LINES);
  localparam logic [CNT_W-1:0] LAST_RSP_C  = CNT_W'(NUM_LINES - 1);

  // One-hot state encoding.
  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_LOAD  = 3'b010,
    S_READY = 3'b100
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [CNT_W-1:0]              r_req_cnt;
  logic [CNT_W-1:0]              w_req_cnt_nxt;
  logic [CNT_W-1:0]              r_rsp_cnt;
  logic [CNT_W-1:0]              w_rsp_cnt_nxt;
  logic                          r_load_cmp;
  logic                          w_load_cmp_nxt;
  logic                          w_req_valid;
  logic                          w_rsp_fire;
  logic                          w_rd_fire;

  logic [TBB_WR_DATA_WIDTH-1:0]  r_mem [NUM_LINES];
  logic [TBB_WR_DATA_WIDTH-1:0]  r_rd_line;
  logic [WORD_SEL_W-1:0]         r_rd_word;
  logic                          r_rd_valid;
  logic                          r_rd_seen;
  logic [TBB_RD_DATA_WIDTH-1:0]  w_rd_word;

  always_comb begin
    w_state_nxt    = r_state;
    w_req_cnt_nxt  = r_req_cnt;
    w_rsp_cnt_nxt  = r_rsp_cnt;
    w_load_cmp_nxt = 1'b0;
    w_req_valid    = 1'b0;
    w_rsp_fire     = 1'b0;
    w_rd_fire      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_cnt_nxt = '0;
        w_rsp_cnt_nxt = '0;
        if (task_start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_req_valid = (r_req_cnt < NUM_LINES_C);
        if (w_req_valid && ReqAck) w_req_cnt_nxt = r_req_cnt + 1'b1;
        w_rsp_fire = RspValid;
        // Responses may come in any order, so completion is decided by count only.
        if (RspValid) begin
          if (r_rsp_cnt == LAST_RSP_C) begin
            w_state_nxt    = S_READY;
            w_load_cmp_nxt = 1'b1;
            w_req_cnt_nxt  = '0;
            w_rsp_cnt_nxt  = '0;
          end else begin
            w_rsp_cnt_nxt = r_rsp_cnt + 1'b1;
          end
        end
      end
      S_READY: begin
        w_rd_fire = RdEn;
        if (task_done) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_req_cnt  <= '0;
      r_rsp_cnt  <= '0;
      r_load_cmp <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_word  <= '0;
      r_rd_seen  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req_cnt  <= w_req_cnt_nxt;
      r_rsp_cnt  <= w_rsp_cnt_nxt;
      r_load_cmp <= w_load_cmp_nxt;
      r_rd_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_rd_word <= RdAddr[WORD_SEL_W-1:0];
        r_rd_seen <= 1'b1;
      end
    end
  end

  // BRAM ports: contents survive reset, so they carry no reset term.
  always_ff @(posedge clk) begin
    if (!reset && w_rsp_fire) r_mem[RspLineIdx] <= RspDin;
    if (!reset && w_rd_fire)  r_rd_line <= r_mem[RdAddr[TBB_RD_ADDR_WIDTH-1:WORD_SEL_W]];
  end

  always_comb begin
    w_rd_word = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (r_rd_word == WORD_SEL_W'(k))
        w_rd_word = r_rd_line[TBB_WR_DATA_WIDTH-1-k*TBB_RD_DATA_WIDTH -: TBB_RD_DATA_WIDTH];
    end
  end

  // r_rd_line is not reset; hide it until the first read after reset.
  assign RdDout     = r_rd_seen ? w_rd_word : '0;
  assign RdValid    = r_rd_valid;
  assign ReqValid   = w_req_valid;
  assign ReqLineIdx = r_req_cnt[TBB_WR_ADDR_WIDTH-1:0];
  assign Ready      = (r_state == S_READY);
  assign Empty      = ~Ready;
  assign LoadCmp    = r_load_cmp;

endmodule
